// File: rtl/arbiter_4rr_if.sv
// ---------------------------------------------------------------------------
// arbiter_4rr_if
// Request/grant bundle between four requesters and the round-robin arbiter.
//   en      : arbiter enable (requester side -> arbiter)
//   req     : request vector, bit i = requester i (requester side -> arbiter)
//   gnt     : registered one-hot grant (arbiter -> requester side)
//   gnt_idx : binary index of the granted requester (arbiter -> requester side)
//   busy    : high while any gnt bit is high (arbiter -> requester side)
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arbiter_4rr_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_idx,
        input  busy
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_idx,
        output busy
    );
endinterface

// File: rtl/arbiter_4rr.sv
// ---------------------------------------------------------------------------
// arbiter_4rr
// Four-requester round-robin arbiter with a registered one-hot grant plus the
// matching encoded index. A hold limit (MAX_HOLD) forces a release once a
// grant has been held that long while another requester is waiting. Every
// release is followed by at least one idle (gnt = 0) cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arbiter_4rr_if.slave (en, req in; gnt, gnt_idx, busy out)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles while another requester waits (>=1)
// ---------------------------------------------------------------------------
module arbiter_4rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter_4rr_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       gnt_p0, gnt_n;
    logic [1:0]       gnt_idx_p0, gnt_idx_n;
    logic             busy_p0, busy_n;

    logic [1:0]       win;
    logic             win_found;
    logic [1:0]       cand;
    logic [3:0]       others;
    logic             release_now;

    // Rotating priority scan: first set request at ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        win       = ptr;
        win_found = 1'b0;
        cand      = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!win_found && bus.req[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // Release priority: enable low, owner dropped its request, then hold limit
    // reached with somebody else waiting.
    always_comb begin
        others              = bus.req;
        others[gnt_idx_p0]  = 1'b0;
        release_now         = !bus.en
                              || !bus.req[gnt_idx_p0]
                              || ((cnt == CNT_MAX) && (others != 4'b0000));
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt_p0;
        gnt_idx_n = gnt_idx_p0;
        busy_n    = busy_p0;
        case (state)
            IDLE: begin
                if (bus.en && win_found) begin
                    state_n   = GRANT;
                    gnt_n     = 4'b0001 << win;
                    gnt_idx_n = win;
                    busy_n    = 1'b1;
                    ptr_n     = win + 2'd1;
                    cnt_n     = '0;
                end else begin
                    gnt_n  = 4'b0000;
                    busy_n = 1'b0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // gnt_idx and ptr are kept; the IDLE cycle that follows is
                    // the mandatory dead cycle.
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    busy_n  = 1'b0;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    // ---- state / output register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            cnt        <= '0;
            gnt_p0     <= 4'b0000;
            gnt_idx_p0 <= 2'd0;
            busy_p0    <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            cnt        <= cnt_n;
            gnt_p0     <= gnt_n;
            gnt_idx_p0 <= gnt_idx_n;
            busy_p0    <= busy_n;
        end
    end

    assign bus.gnt     = gnt_p0;
    assign bus.gnt_idx = gnt_idx_p0;
    assign bus.busy    = busy_p0;

endmodule

// File: tb/tb_arbiter_4rr.sv
// ---------------------------------------------------------------------------
// tb_arbiter_4rr
// Directed bench for arbiter_4rr: a MAX_HOLD=8 instance (table-driven vectors
// plus rotation, hold, reset sequences) and a MAX_HOLD=1 instance for the
// alternation case. Structural invariants are checked every falling edge.
// ---------------------------------------------------------------------------
module tb_arbiter_4rr;

    logic clk;
    logic rst_n;

    arbiter_4rr_if bus8 ();
    arbiter_4rr_if bus1 ();

    arbiter_4rr #(.MAX_HOLD(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    arbiter_4rr #(.MAX_HOLD(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       busy;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, got, exp);
    endtask

    task automatic chk8(input string nm, input logic [3:0] g, input logic [1:0] i, input logic b);
        chk({nm, ".gnt"}, bus8.gnt, g);
        chk({nm, ".idx"}, {2'b00, bus8.gnt_idx}, {2'b00, i});
        chk({nm, ".busy"}, {3'b000, bus8.busy}, {3'b000, b});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic inv_ok(input logic [3:0] g, input logic [1:0] i, input logic b);
        logic [3:0] oh;
        oh = 4'b0001 << i;
        return $onehot0(g) && (b == (|g)) && (!b || (g == oh));
    endfunction

    // Invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        n_chk++;
        if (inv_ok(bus8.gnt, bus8.gnt_idx, bus8.busy)) n_pass++;
        else $display("FAIL invariant8: gnt=%b idx=%0d busy=%b", bus8.gnt, bus8.gnt_idx, bus8.busy);
        n_chk++;
        if (inv_ok(bus1.gnt, bus1.gnt_idx, bus1.busy)) n_pass++;
        else $display("FAIL invariant1: gnt=%b idx=%0d busy=%b", bus1.gnt, bus1.gnt_idx, bus1.busy);
    end

    initial begin
        // Starts in IDLE with ptr=1, last gnt_idx=0.
        tbl[0]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};  // grant 1
        tbl[1]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[2]  = '{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1};  // third cycle
        tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0};  // voluntary release, idx held
        tbl[4]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};  // ptr=2 wraps to 0
        tbl[5]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 1'b1};
        tbl[6]  = '{1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0};  // owner drops
        tbl[7]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};  // disabled
        tbl[8]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 1'b1};  // enable -> grant ptr=1
        tbl[10] = '{1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0};  // en drop revokes
        tbl[11] = '{1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0};
        tbl[12] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};  // en and req drop together
        tbl[14] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[15] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[16] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};  // waiter below limit: no effect
        tbl[17] = '{1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[18] = '{1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0};

        rst_n    = 1'b0;
        bus8.en  = 1'b0;
        bus8.req = 4'b0000;
        bus1.en  = 1'b1;
        bus1.req = 4'b0000;

        #12;
        chk8("reset", 4'b0000, 2'd0, 1'b0);

        // Reset release mid-cycle; first edge samples nothing.
        rst_n   = 1'b1;
        bus8.en = 1'b1;
        step();
        chk8("post_reset_idle", 4'b0000, 2'd0, 1'b0);
        bus8.req = 4'b1111;
        step();
        chk8("first_grant", 4'b0001, 2'd0, 1'b1);
        bus8.req = 4'b0000;
        step();
        chk8("first_release", 4'b0000, 2'd0, 1'b0);

        for (int v = 0; v < 19; v++) begin
            bus8.en  = tbl[v].en;
            bus8.req = tbl[v].req;
            step();
            chk8($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].idx, tbl[v].busy);
        end

        // Rotation: all requesting, ptr=0. Grants 0,1,2,3,0 of 8 cycles + 1 dead.
        bus8.en  = 1'b1;
        bus8.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                chk($sformatf("rot%0d_c%0d.gnt", g, c), bus8.gnt, 4'b0001 << (g % 4));
                chk($sformatf("rot%0d_c%0d.idx", g, c), {2'b00, bus8.gnt_idx}, 4'(g % 4));
            end
            step();
            chk($sformatf("rot%0d_dead", g), bus8.gnt, 4'b0000);
        end
        bus8.req = 4'b0000;
        step();
        chk("rot_end", bus8.gnt, 4'b0000);

        // Hold without contention: ptr=1, only requester 3.
        bus8.req = 4'b1000;
        for (int c = 0; c < 20; c++) begin
            step();
            chk($sformatf("hold_c%0d", c), bus8.gnt, 4'b1000);
        end
        bus8.req = 4'b1001;
        step();
        chk8("hold_forced_release", 4'b0000, 2'd3, 1'b0);
        step();
        chk8("hold_next_grant", 4'b0001, 2'd0, 1'b1);
        bus8.req = 4'b0000;
        step();
        chk("hold_end", bus8.gnt, 4'b0000);

        // Asynchronous reset mid-grant (ptr=1 -> requester 2 wins).
        bus8.req = 4'b0100;
        step();
        chk8("pre_reset_grant", 4'b0100, 2'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk8("async_reset", 4'b0000, 2'd0, 1'b0);
        bus8.req = 4'b0000;
        step();
        chk8("reset_held", 4'b0000, 2'd0, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        chk("after_reset_idle", bus8.gnt, 4'b0000);
        bus8.req = 4'b1111;
        step();
        chk8("after_reset_ptr0", 4'b0001, 2'd0, 1'b1);
        bus8.req = 4'b0000;
        step();
        chk("after_reset_release", bus8.gnt, 4'b0000);

        // MAX_HOLD=1 instance: alternation between requesters 0 and 2.
        bus1.req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            step();
            case (c % 4)
                0:       chk($sformatf("mh1_c%0d", c), bus1.gnt, 4'b0001);
                2:       chk($sformatf("mh1_c%0d", c), bus1.gnt, 4'b0100);
                default: chk($sformatf("mh1_c%0d", c), bus1.gnt, 4'b0000);
            endcase
        end
        bus1.req = 4'b0000;
        step();
        chk("mh1_end", bus1.gnt, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
